gd_controller_nd: RTL and testbench
===================================

// Module: gd_controller_nd
// PURPOSE
//  Parametrised N-dimensional gradient-descent sequencer, successor to the fixed 4-D controller.
//  Iterates a point vector against an external function/gradient evaluator over a valid/ready request and response handshake.
//  Tracks the best value and its point, and stops on iteration limit, convergence patience or abort.
//  Sits between the top-level start/done control and the evaluator datapath.
// PARAMETERS
//  NUM_DIMS   4             number of coordinates (>=1)
//  COORD_W    16            signed coordinate/gradient width, Q(COORD_W-8).8
//  VAL_W      32            signed function value width, Q(VAL_W-8).8
//  MAX_ITER   50            evaluations before forced stop (>=1)
//  CONV_TOL   32'h0000_0010 convergence window |z - z_prev| < CONV_TOL (0.0625)
//  PATIENCE   2             consecutive in-window iterations required to declare convergence (>=1)
//  LR_SHIFT   3             step = grad >>> LR_SHIFT (arithmetic), i.e. learning rate 2^-LR_SHIFT
// PORTS
//  clk         in   1                 clock, all logic on posedge
//  rst         in   1                 synchronous, active-high reset
//  start       in   1                 level; rising into IDLE launches a run
//  abort       in   1                 terminate run early
//  init_vec    in   NUM_DIMS*COORD_W  start point, dim k at [k*COORD_W +: COORD_W]
//  eval_valid  out  1                 request to evaluator
//  eval_ready  in   1                 evaluator accepts request
//  eval_point  out  NUM_DIMS*COORD_W  point to evaluate
//  res_valid   in   1                 evaluator result strobe
//  res_value   in   VAL_W             f(point)
//  res_grad    in   NUM_DIMS*COORD_W  gradient at point
//  busy        out  1                 run in progress
//  done        out  1                 run finished, held until start low
//  status      out  2                 00 iter limit, 01 converged, 10 aborted
//  z_min       out  VAL_W             best value found
//  point_min   out  NUM_DIMS*COORD_W  point at z_min
//  iter_count  out  $clog2(MAX_ITER+1) completed evaluations
// BEHAVIOUR
//  Reset: state IDLE; eval_valid=busy=done=0, status=00, iter_count=0, point_min=eval_point=0, z_min=max positive.
//  States: IDLE, LOAD, REQ, WAIT, UPDATE, DONE.
//  IDLE: start=1 -> LOAD.
//  LOAD (1 cycle): cur_point<=init_vec, point_min<=init_vec; z_min<=max positive; z_prev invalid;
//    iter_count<=0, conv_cnt<=0, busy<=1 -> REQ.
//  REQ: eval_valid=1 with eval_point=cur_point, both stable until eval_valid&eval_ready -> WAIT.
//  WAIT: on res_valid capture value/grad, iter_count++ -> UPDATE. res_valid outside WAIT is ignored.
//  UPDATE (1 cycle), in priority order:
//    - value < z_min (signed, strict) -> z_min/point_min <= value/cur_point.
//    - z_prev valid and |value-z_prev| < CONV_TOL (computed at VAL_W+1 bits) -> conv_cnt++, else conv_cnt<=0.
//    - conv_cnt reaching PATIENCE -> DONE, status 01.
//    - else iter_count==MAX_ITER -> DONE, status 00. Converged wins when both hold.
//    - else cur_point[k] <= sat(cur_point[k] - (grad[k]>>>LR_SHIFT)), z_prev<=value -> REQ.
//  Coordinate subtract at COORD_W+1 bits, saturated to [-2^(COORD_W-1), 2^(COORD_W-1)-1]; never wraps.
//  Iteration latency = 3 cycles + evaluator latency (REQ 1 cycle if ready, WAIT >= 1, UPDATE 1).
//  DONE: done=1, busy=0, eval_valid=0; results frozen; start=0 -> IDLE. done clears on IDLE entry.
//  abort=1 in LOAD/REQ/WAIT/UPDATE -> DONE next cycle, status 10; a result arriving the same cycle is discarded.
//  start while busy or in DONE is ignored. rst mid-run returns to reset values next cycle, dropping any outstanding request.
// CONFIGURATION
//  ADAPTIVE_STEP_EN defined: internal shift starts at LR_SHIFT on LOAD. In UPDATE, if z_prev is valid and value > z_prev:
//    shift <= min(shift+1, COORD_W-1); cur_point <= point_min (no step); conv_cnt <= 0; z_prev unchanged.
//    Steps use the current shift.
//  ADAPTIVE_STEP_EN undefined: fixed LR_SHIFT, and increases are stepped normally.
// TESTING
//  1 rst held 2 cycles while in WAIT -> next cycle IDLE, eval_valid=0, busy=0, z_min=32'h7FFF_FFFF.
//  2 NUM_DIMS=2, LR_SHIFT=2, model f=x^2+y^2, grad=2x, init (16'h0200,16'hFF00)
//    -> eval_point 0200/FF00, 0100/FF80, 0080/FFC0..., z_min strictly decreasing, done with status 01.
//  3 MAX_ITER=5, grad=0, value falls 32'h100 per eval -> done after 5th result, status 00, iter_count=5, z_min=last value.
//  4 LR_SHIFT=0, coord 16'h7F00, grad 16'h8000 -> next eval_point coord 16'h7FFF (saturated); mirror case -> 16'h8000.
//  5 abort asserted in WAIT, same cycle as res_valid -> status 10, z_min/point_min equal prior best.
//  6 eval_ready low 10 cycles -> eval_valid/eval_point stable; start toggled while busy has no effect.

Source files
------------

// File: rtl/gd_controller_nd.sv
// gd_controller_nd: N-dimensional gradient-descent sequencer.
// Drives a point vector to an external function/gradient evaluator over a
// valid/ready request and a result strobe. Tracks the best value and its
// point, and stops on iteration limit, convergence patience or abort.
// Optional feature macro: ADAPTIVE_STEP_EN. When it is defined, the step
// shift grows and the point reverts to the best point whenever the value
// increases.
module gd_controller_nd #(
    parameter int unsigned NUM_DIMS = 4,
    parameter int unsigned COORD_W  = 16,
    parameter int unsigned VAL_W    = 32,
    parameter int unsigned MAX_ITER = 50,
    parameter logic [31:0] CONV_TOL = 32'h0000_0010,
    parameter int unsigned PATIENCE = 2,
    parameter int unsigned LR_SHIFT = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [NUM_DIMS*COORD_W-1:0]     init_vec,
    output logic                            eval_valid,
    input  logic                            eval_ready,
    output logic [NUM_DIMS*COORD_W-1:0]     eval_point,
    input  logic                            res_valid,
    input  logic [VAL_W-1:0]                res_value,
    input  logic [NUM_DIMS*COORD_W-1:0]     res_grad,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      status,
    output logic [VAL_W-1:0]                z_min,
    output logic [NUM_DIMS*COORD_W-1:0]     point_min,
    output logic [$clog2(MAX_ITER+1)-1:0]   iter_count
);

    localparam int unsigned IW = $clog2(MAX_ITER + 1);
    localparam int unsigned CW = (PATIENCE > 0) ? $clog2(PATIENCE + 1) : 1;
    localparam int unsigned SW = (COORD_W > 1) ? $clog2(COORD_W) : 1;
    localparam int unsigned PW = NUM_DIMS * COORD_W;
    localparam int unsigned TW = (VAL_W + 1 > 32) ? VAL_W + 1 : 32;

    localparam logic [VAL_W-1:0]   L_VMAX = {1'b0, {(VAL_W-1){1'b1}}};
    localparam logic [COORD_W-1:0] L_CMAX = {1'b0, {(COORD_W-1){1'b1}}};
    localparam logic [COORD_W-1:0] L_CMIN = {1'b1, {(COORD_W-1){1'b0}}};

    localparam logic [1:0] ST_ITER  = 2'b00;
    localparam logic [1:0] ST_CONV  = 2'b01;
    localparam logic [1:0] ST_ABORT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [PW-1:0]     r_cur_point;
    logic [PW-1:0]     r_point_min;
    logic [PW-1:0]     r_grad;
    logic [VAL_W-1:0]  r_value;
    logic [VAL_W-1:0]  r_zmin;
    logic [VAL_W-1:0]  r_zprev;
    logic              r_zprev_valid;
    logic [IW-1:0]     r_iter;
    logic [CW-1:0]     r_conv_cnt;
    logic              r_busy;
    logic [1:0]        r_status;

    logic [SW-1:0]     w_shift;
    logic              w_worse;
    logic              w_better;
    logic [VAL_W:0]    w_diff;
    logic [VAL_W:0]    w_abs;
    logic [TW-1:0]     w_abs_x;
    logic [TW-1:0]     w_tol_x;
    logic              w_in_win;
    logic [CW-1:0]     w_conv_nxt;
    logic              w_converged;
    logic              w_iter_hit;
    logic              w_to_done;
    logic [1:0]        w_status_nxt;
    logic [PW-1:0]     w_next_point;

`ifdef ADAPTIVE_STEP_EN
    logic [SW-1:0]     r_shift;

    assign w_shift = r_shift;
    assign w_worse = r_zprev_valid && ($signed(r_value) > $signed(r_zprev));
`else
    assign w_shift = SW'(LR_SHIFT);
    assign w_worse = 1'b0;
`endif

    assign w_better = $signed(r_value) < $signed(r_zmin);

    // Distance to the previous value, widened by one bit so it never wraps
    assign w_diff  = {r_value[VAL_W-1], r_value} - {r_zprev[VAL_W-1], r_zprev};
    assign w_abs   = w_diff[VAL_W] ? (~w_diff + 1'b1) : w_diff;
    assign w_abs_x = TW'(w_abs);
    assign w_tol_x = TW'(CONV_TOL);
    assign w_in_win = r_zprev_valid && (w_abs_x < w_tol_x);

    assign w_conv_nxt  = (w_in_win && !w_worse) ? (r_conv_cnt + 1'b1) : '0;
    assign w_converged = (w_conv_nxt == CW'(PATIENCE));
    assign w_iter_hit  = (r_iter == IW'(MAX_ITER));

    // Per-coordinate step with saturation on the widened difference
    for (genvar k = 0; k < NUM_DIMS; k++) begin : g_step
        logic signed [COORD_W-1:0] w_c;
        logic signed [COORD_W-1:0] w_g;
        logic signed [COORD_W-1:0] w_s;
        logic        [COORD_W:0]   w_d;

        assign w_c = r_cur_point[k*COORD_W +: COORD_W];
        assign w_g = r_grad[k*COORD_W +: COORD_W];
        assign w_s = w_g >>> w_shift;
        assign w_d = {w_c[COORD_W-1], w_c} - {w_s[COORD_W-1], w_s};
        assign w_next_point[k*COORD_W +: COORD_W] =
            (w_d[COORD_W] != w_d[COORD_W-1]) ? (w_d[COORD_W] ? L_CMIN : L_CMAX)
                                             : w_d[COORD_W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, request strobe and stop classification
    always_comb begin
        w_state_nxt  = r_state;
        eval_valid   = 1'b0;
        w_status_nxt = ST_ITER;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = abort ? S_DONE : S_REQ;
            end
            S_REQ: begin
                eval_valid = 1'b1;
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (eval_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_state_nxt = S_DONE;
                end else if (res_valid) begin
                    w_state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (abort || w_converged || w_iter_hit) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            w_status_nxt = ST_ABORT;
        end else if (w_converged) begin
            w_status_nxt = ST_CONV;
        end
        w_to_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);
    end

    // Datapath: point, best-so-far, convergence and iteration bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_point   <= '0;
            r_point_min   <= '0;
            r_grad        <= '0;
            r_value       <= '0;
            r_zmin        <= L_VMAX;
            r_zprev       <= '0;
            r_zprev_valid <= 1'b0;
            r_iter        <= '0;
            r_conv_cnt    <= '0;
            r_busy        <= 1'b0;
            r_status      <= ST_ITER;
`ifdef ADAPTIVE_STEP_EN
            r_shift       <= SW'(LR_SHIFT);
`endif
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_cur_point   <= init_vec;
                    r_point_min   <= init_vec;
                    r_zmin        <= L_VMAX;
                    r_zprev_valid <= 1'b0;
                    r_iter        <= '0;
                    r_conv_cnt    <= '0;
                    r_busy        <= 1'b1;
                    r_status      <= ST_ITER;
`ifdef ADAPTIVE_STEP_EN
                    r_shift       <= SW'(LR_SHIFT);
`endif
                end
                S_WAIT: begin
                    if (!abort && res_valid) begin
                        r_value <= res_value;
                        r_grad  <= res_grad;
                        r_iter  <= r_iter + 1'b1;
                    end
                end
                S_UPDATE: begin
                    if (!abort) begin
                        if (w_better) begin
                            r_zmin      <= r_value;
                            r_point_min <= r_cur_point;
                        end
                        r_conv_cnt <= w_conv_nxt;
                        if (!w_converged && !w_iter_hit) begin
                            if (w_worse) begin
                                // A worse value restarts from the best point with a smaller step
                                r_cur_point <= r_point_min;
`ifdef ADAPTIVE_STEP_EN
                                if (r_shift < SW'(COORD_W - 1)) begin
                                    r_shift <= r_shift + 1'b1;
                                end
`endif
                            end else begin
                                r_cur_point   <= w_next_point;
                                r_zprev       <= r_value;
                                r_zprev_valid <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
            if (w_to_done) begin
                r_busy   <= 1'b0;
                r_status <= w_status_nxt;
            end
        end
    end

    assign eval_point = r_cur_point;
    assign busy       = r_busy;
    assign done       = (r_state == S_DONE);
    assign status     = r_status;
    assign z_min      = r_zmin;
    assign point_min  = r_point_min;
    assign iter_count = r_iter;

endmodule

// File: tb/tb_gd_controller_nd.sv
// Directed, table-driven bench for gd_controller_nd (2-D, LR_SHIFT=2,
// MAX_ITER=6, PATIENCE=2). The evaluator side is driven from a vector table;
// reset, saturation, abort and stall cases are hand-written sequences.
module tb_gd_controller_nd;

    localparam int unsigned ND = 2;
    localparam int unsigned CW = 16;
    localparam int unsigned VW = 32;
    localparam int unsigned MI = 6;
    localparam int unsigned IW = $clog2(MI + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ND*CW-1:0]  init_vec = '0;
    logic              eval_valid;
    logic              eval_ready = 1'b0;
    logic [ND*CW-1:0]  eval_point;
    logic              res_valid = 1'b0;
    logic [VW-1:0]     res_value = '0;
    logic [ND*CW-1:0]  res_grad = '0;
    logic              busy;
    logic              done;
    logic [1:0]        status;
    logic [VW-1:0]     z_min;
    logic [ND*CW-1:0]  point_min;
    logic [IW-1:0]     iter_count;

    always #5 clk = ~clk;

    gd_controller_nd #(
        .NUM_DIMS (ND),
        .COORD_W  (CW),
        .VAL_W    (VW),
        .MAX_ITER (MI),
        .CONV_TOL (32'h0000_0010),
        .PATIENCE (2),
        .LR_SHIFT (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .init_vec   (init_vec),
        .eval_valid (eval_valid),
        .eval_ready (eval_ready),
        .eval_point (eval_point),
        .res_valid  (res_valid),
        .res_value  (res_value),
        .res_grad   (res_grad),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .z_min      (z_min),
        .point_min  (point_min),
        .iter_count (iter_count)
    );

    typedef struct {
        logic [31:0] exp_point;
        logic [31:0] value;
        logic [31:0] grad;
        logic [31:0] exp_zmin;
    } vec_t;

    vec_t vecs[13];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] iv);
        init_vec = iv;
        start    = 1'b1;
        tick();
        tick();
        check("run_busy", 64'(busy), 64'd1);
        check("run_req", 64'(eval_valid), 64'd1);
        check("run_point", 64'(eval_point), 64'(iv));
        check("run_zmin", 64'(z_min), 64'h7FFF_FFFF);
        check("run_iter", 64'(iter_count), 64'd0);
    endtask

    task automatic do_iter(input int idx);
        int guard = 0;
        while (!eval_valid && guard < 50) begin
            tick();
            guard++;
        end
        check($sformatf("vec%0d_req", idx), 64'(eval_valid), 64'd1);
        if (eval_valid) begin
            check($sformatf("vec%0d_point", idx), 64'(eval_point), 64'(vecs[idx].exp_point));
            eval_ready = 1'b1;
            tick();
            eval_ready = 1'b0;
            check($sformatf("vec%0d_wait_novalid", idx), 64'(eval_valid), 64'd0);
            res_valid = 1'b1;
            res_value = vecs[idx].value;
            res_grad  = vecs[idx].grad;
            tick();
            res_valid = 1'b0;
            tick();
            check($sformatf("vec%0d_zmin", idx), 64'(z_min), 64'(vecs[idx].exp_zmin));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // f = x^2 + y^2 in Q8, grad = 2x/2y; each step halves the point
        vecs[0]  = '{32'hFF00_0200, 32'h0000_0500, 32'hFE00_0400, 32'h0000_0500};
        vecs[1]  = '{32'hFF80_0100, 32'h0000_0140, 32'hFF00_0200, 32'h0000_0140};
        vecs[2]  = '{32'hFFC0_0080, 32'h0000_0050, 32'hFF80_0100, 32'h0000_0050};
        vecs[3]  = '{32'hFFE0_0040, 32'h0000_0014, 32'hFFC0_0080, 32'h0000_0014};
        vecs[4]  = '{32'hFFF0_0020, 32'h0000_0005, 32'hFFE0_0040, 32'h0000_0005};
        vecs[5]  = '{32'hFFF8_0010, 32'h0000_0001, 32'hFFF0_0020, 32'h0000_0001};
        // zero gradient, value falling 0x100 per evaluation
        vecs[6]  = '{32'h0100_0100, 32'h0000_1000, 32'h0000_0000, 32'h0000_1000};
        vecs[7]  = '{32'h0100_0100, 32'h0000_0F00, 32'h0000_0000, 32'h0000_0F00};
        vecs[8]  = '{32'h0100_0100, 32'h0000_0E00, 32'h0000_0000, 32'h0000_0E00};
        vecs[9]  = '{32'h0100_0100, 32'h0000_0D00, 32'h0000_0000, 32'h0000_0D00};
        vecs[10] = '{32'h0100_0100, 32'h0000_0C00, 32'h0000_0000, 32'h0000_0C00};
        vecs[11] = '{32'h0100_0100, 32'h0000_0B00, 32'h0000_0000, 32'h0000_0B00};
        // near-limit coordinates with extreme gradients
        vecs[12] = '{32'h8100_7F00, 32'h0000_2000, 32'h7FFF_8000, 32'h0000_2000};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(eval_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_iter", 64'(iter_count), 64'd0);
        check("rst_point", 64'(eval_point), 64'd0);
        check("rst_pmin", 64'(point_min), 64'd0);
        check("rst_zmin", 64'(z_min), 64'h7FFF_FFFF);

        // Reset held while waiting for a result
        start_run(32'hFF00_0200);
        start = 1'b0;
        eval_ready = 1'b1;
        tick();
        eval_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_valid", 64'(eval_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_zmin", 64'(z_min), 64'h7FFF_FFFF);
        tick();
        rst = 1'b0;
        tick();
        check("midrst_idle_valid", 64'(eval_valid), 64'd0);
        check("midrst_idle_done", 64'(done), 64'd0);

        // Converging descent; convergence and iteration limit coincide
        start_run(32'hFF00_0200);
        for (int i = 0; i < 6; i++) begin
            do_iter(i);
        end
        check("conv_done", 64'(done), 64'd1);
        check("conv_busy", 64'(busy), 64'd0);
        check("conv_status", 64'(status), 64'd1);
        check("conv_iter", 64'(iter_count), 64'd6);
        check("conv_pmin", 64'(point_min), 64'hFFF8_0010);
        tick();
        check("conv_done_held", 64'(done), 64'd1);
        check("conv_valid_held", 64'(eval_valid), 64'd0);
        start = 1'b0;
        tick();
        check("conv_idle_done", 64'(done), 64'd0);

        // Iteration limit, preceded by a ready stall with start toggling
        start_run(32'h0100_0100);
        for (int i = 0; i < 10; i++) begin
            start = ~start;
            tick();
            check($sformatf("stall%0d_valid", i), 64'(eval_valid), 64'd1);
            check($sformatf("stall%0d_point", i), 64'(eval_point), 64'h0100_0100);
        end
        start = 1'b0;
        for (int i = 6; i < 12; i++) begin
            do_iter(i);
        end
        check("lim_done", 64'(done), 64'd1);
        check("lim_status", 64'(status), 64'd0);
        check("lim_iter", 64'(iter_count), 64'd6);
        check("lim_zmin", 64'(z_min), 64'h0000_0B00);
        check("lim_pmin", 64'(point_min), 64'h0100_0100);
        tick();
        check("lim_idle_done", 64'(done), 64'd0);

        // Saturating step, then abort racing a better result
        start_run(32'h8100_7F00);
        start = 1'b0;
        do_iter(12);
        check("sat_req", 64'(eval_valid), 64'd1);
        check("sat_point", 64'(eval_point), 64'h8000_7FFF);
        eval_ready = 1'b1;
        tick();
        eval_ready = 1'b0;
        abort     = 1'b1;
        res_valid = 1'b1;
        res_value = 32'h0000_0100;
        res_grad  = 32'h0000_0000;
        tick();
        abort     = 1'b0;
        res_valid = 1'b0;
        check("abort_done", 64'(done), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_status", 64'(status), 64'd2);
        check("abort_zmin", 64'(z_min), 64'h0000_2000);
        check("abort_pmin", 64'(point_min), 64'h8100_7F00);
        check("abort_iter", 64'(iter_count), 64'd1);
        tick();
        check("abort_idle_done", 64'(done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
